// File: rtl/dac_stream_fifo.sv
// dac_stream_fifo: first-word-fall-through AXI-Stream FIFO that feeds the DAC
// signal splitter. It reports occupancy, raises a sticky primed flag once enough
// batches are buffered, and counts starved cycles after priming.
module dac_stream_fifo #(
  parameter int DATA_WIDTH  = 256,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                      m_axis_aclk,
  input  logic                      m_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic                      M_AXIS_tvalid,
  input  logic                      M_AXIS_tready,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      primed,
  output logic [CNT_WIDTH-1:0]      underflow_count,
  input  logic                      clear_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          PTR_ONE    = (AW+1)'(1);
  localparam logic [AW:0]          PRIME_FILL = (AW+1)'(PRIME_LEVEL);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  // Storage is not reset: stale contents are never visible because the
  // pointers define what is valid.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] fill_next;
  logic        primed_reg;
  logic [CNT_WIDTH-1:0] underflow_reg;

  logic empty;
  logic full;
  logic wr_en;
  logic rd_en;
  logic underflow_event;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // Ready is held low while reset is asserted so nothing is accepted then;
  // otherwise it depends only on registered pointers.
  assign S_AXIS_tready = m_axis_aresetn & ~full;
  assign M_AXIS_tvalid = ~empty;
  assign M_AXIS_tdata  = mem[rd_ptr_reg[AW-1:0]];

  assign wr_en = S_AXIS_tvalid & S_AXIS_tready;
  assign rd_en = M_AXIS_tvalid & M_AXIS_tready;

  // A starved cycle only matters once playback has been primed.
  assign underflow_event = primed_reg & M_AXIS_tready & empty;

  assign fill_level      = wr_ptr_reg - rd_ptr_reg;
  assign primed          = primed_reg;
  assign underflow_count = underflow_reg;

  // Next-state pointers and the occupancy they imply after this edge.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    fill_next = wr_ptr_next - rd_ptr_next;
  end

  // Write port of the batch storage.
  always_ff @(posedge m_axis_aclk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= S_AXIS_tdata;
    end
  end

  // Pointer and primed-flag state; reset discards everything buffered.
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      primed_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (fill_next >= PRIME_FILL) begin
        primed_reg <= 1'b1;
      end
    end
  end

  // Saturating underflow counter; a clear wins over a coincident event.
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      underflow_reg <= '0;
    end else if (clear_underflow) begin
      underflow_reg <= '0;
    end else if (underflow_event && (underflow_reg != CNT_MAX)) begin
      underflow_reg <= underflow_reg + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_dac_stream_fifo.sv
// Self-checking bench for dac_stream_fifo: a queue-based reference model tracks
// accepted batches and status; a negedge monitor checks outputs and pops data.
module tb_dac_stream_fifo;
  localparam int DW    = 256;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [LW-1:0] fill_level;
  logic          primed;
  logic [CW-1:0] underflow_count;
  logic          clear_uf = 1'b0;

  always #5 clk = ~clk;

  dac_stream_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .CNT_WIDTH(CW)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (aresetn),
    .S_AXIS_tdata   (s_tdata),
    .S_AXIS_tvalid  (s_tvalid),
    .S_AXIS_tready  (s_tready),
    .M_AXIS_tdata   (m_tdata),
    .M_AXIS_tvalid  (m_tvalid),
    .M_AXIS_tready  (m_tready),
    .fill_level     (fill_level),
    .primed         (primed),
    .underflow_count(underflow_count),
    .clear_underflow(clear_uf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rnd_batch();
    logic [DW-1:0] r;
    for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: occupancy as an integer, accepted data in a scoreboard queue.
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] recv_q[$];
  int  m_cnt = 0;
  bit  m_primed = 0;
  int  m_uf = 0;
  bit  chk_en = 0;

  // Model update from the inputs present at each rising edge.
  always @(posedge clk) begin
    bit wr, rd, ev;
    if (!aresetn) begin
      sb_q.delete();
      m_cnt = 0;
      m_primed = 0;
      m_uf = 0;
    end else begin
      wr = s_tvalid && (m_cnt < DEPTH);
      rd = m_tready && (m_cnt > 0);
      ev = m_primed && m_tready && (m_cnt == 0);
      if (wr) sb_q.push_back(s_tdata);
      m_cnt = m_cnt + int'(wr) - int'(rd);
      if (m_cnt >= PRIME) m_primed = 1;
      if (clear_uf) m_uf = 0;
      else if (ev && m_uf < (1 << CW) - 1) m_uf++;
    end
  end

  // Monitor: compare status every cycle and pop data on each pending transfer.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_tready", DW'(s_tready), DW'(aresetn && (m_cnt < DEPTH)));
      chk("m_tvalid", DW'(m_tvalid), DW'(m_cnt > 0));
      chk("fill_level", DW'(fill_level), DW'(m_cnt));
      chk("primed", DW'(primed), DW'(m_primed));
      chk("underflow_count", DW'(underflow_count), DW'(m_uf));
      if (aresetn && m_tvalid && m_tready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL m_tdata_unexpected: got %0h expected no transfer", m_tdata);
        end else begin
          chk("m_tdata", m_tdata, sb_q.pop_front());
          recv_q.push_back(m_tdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] a5;
    logic [DW-1:0] b11;
    a5  = {32{8'hA5}};
    b11 = {32{8'h11}};

    // Reset held for three edges, then released.
    step();
    chk_en = 1;
    step();
    step();
    aresetn = 1'b1;
    step();
    chk("rst_s_tready", DW'(s_tready), DW'(1));
    chk("rst_m_tvalid", DW'(m_tvalid), DW'(0));
    chk("rst_fill", DW'(fill_level), DW'(0));
    chk("rst_primed", DW'(primed), DW'(0));
    chk("rst_uf", DW'(underflow_count), DW'(0));

    // Single batch: one-cycle fall-through latency, then one transfer.
    s_tdata = a5;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("one_tvalid", DW'(m_tvalid), DW'(1));
    chk("one_tdata", m_tdata, a5);
    chk("one_fill", DW'(fill_level), DW'(1));
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    chk("one_drained_tvalid", DW'(m_tvalid), DW'(0));
    chk("one_drained_fill", DW'(fill_level), DW'(0));

    // Fill to full; primed appears with the eighth write.
    for (int i = 0; i < DEPTH; i++) begin
      s_tdata = rnd_batch();
      s_tvalid = 1'b1;
      step();
      if (i == PRIME - 2) chk("primed_before", DW'(primed), DW'(0));
      if (i == PRIME - 1) chk("primed_at", DW'(primed), DW'(1));
    end
    chk("full_fill", DW'(fill_level), DW'(DEPTH));
    chk("full_s_tready", DW'(s_tready), DW'(0));
    s_tdata = rnd_batch();
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("full_read_fill", DW'(fill_level), DW'(DEPTH - 1));
    chk("full_read_s_tready", DW'(s_tready), DW'(1));

    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    step();

    // Ordering and wrap-around with random stalls on both sides.
    recv_q.delete();
    fork
      begin
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < 40 && cyc < 2000) begin
          s_tvalid = ($urandom_range(0, 3) != 0);
          s_tdata = DW'(idx);
          @(negedge clk);
          acc = s_tvalid && s_tready;
          step();
          if (acc) idx++;
          cyc++;
        end
        s_tvalid = 1'b0;
      end
      begin
        int cyc = 0;
        while (recv_q.size() < 40 && cyc < 3000) begin
          m_tready = ($urandom_range(0, 2) != 0);
          step();
          cyc++;
        end
        m_tready = 1'b0;
      end
    join
    chk("order_count", DW'(recv_q.size()), DW'(40));
    for (int i = 0; i < recv_q.size() && i < 40; i++) begin
      chk($sformatf("order_%0d", i), recv_q[i], DW'(i));
    end

    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    step();

    // Underflow: ignored before priming, counted after, clear wins.
    m_tready = 1'b1;
    repeat (4) step();
    chk("uf_unprimed", DW'(underflow_count), DW'(0));
    m_tready = 1'b0;
    for (int i = 0; i < PRIME; i++) begin
      s_tdata = rnd_batch();
      s_tvalid = 1'b1;
      step();
    end
    s_tvalid = 1'b0;
    chk("uf_primed", DW'(primed), DW'(1));
    m_tready = 1'b1;
    repeat (PRIME + 5) step();
    chk("uf_count5", DW'(underflow_count), DW'(5));
    chk("uf_drained_fill", DW'(fill_level), DW'(0));
    clear_uf = 1'b1;
    step();
    clear_uf = 1'b0;
    chk("uf_cleared", DW'(underflow_count), DW'(0));
    m_tready = 1'b0;
    step();

    // Mid-stream reset with six batches buffered.
    for (int i = 0; i < 6; i++) begin
      s_tdata = rnd_batch();
      s_tvalid = 1'b1;
      step();
    end
    s_tvalid = 1'b0;
    chk("mid_fill6", DW'(fill_level), DW'(6));
    aresetn = 1'b0;
    step();
    chk("mid_rst_fill", DW'(fill_level), DW'(0));
    chk("mid_rst_tvalid", DW'(m_tvalid), DW'(0));
    chk("mid_rst_primed", DW'(primed), DW'(0));
    aresetn = 1'b1;
    s_tdata = b11;
    s_tvalid = 1'b1;
    recv_q.delete();
    step();
    s_tvalid = 1'b0;
    chk("mid_first_tdata", m_tdata, b11);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    chk("mid_recv_count", DW'(recv_q.size()), DW'(1));
    if (recv_q.size() > 0) chk("mid_recv_first", recv_q[0], b11);
    chk("mid_end_fill", DW'(fill_level), DW'(0));
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
